per2apb_bridge: RTL

PER2APB_BRIDGE -- requirements
Module: per2apb_bridge

---
 rtl/per2apb_bridge.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/per2apb_bridge.sv
// per2apb_bridge: bridges a req/gnt peripheral port onto an APB master.
// Each request becomes one APB read, one APB write, or a read-modify-write
// for partial byte enables. A write with no byte enables completes at once
// without touching APB. A single response pulse returns data, error and ID.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   per_slave_req_i/gnt_o          request handshake (gnt only in IDLE)
//   per_slave_add_i/we_i/wdata_i   request address, direction, write data
//   per_slave_be_i/id_i            byte enables, transaction ID
//   per_slave_r_valid_o            one-cycle response pulse
//   per_slave_r_opc_o              1 = error (pslverr or timeout)
//   per_slave_r_rdata_o/r_id_o     read data, echoed ID
//   paddr_o/pwdata_o/pwrite_o      APB address, write data, direction
//   psel_o/penable_o               APB phase control
//   prdata_i/pready_i/pslverr_i    APB completion inputs
module per2apb_bridge #(
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      per_slave_req_i,
    input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
    input  logic                      per_slave_we_i,
    input  logic [31:0]               per_slave_wdata_i,
    input  logic [3:0]                per_slave_be_i,
    input  logic [ID_WIDTH-1:0]       per_slave_id_i,
    output logic                      per_slave_gnt_o,
    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [31:0]               per_slave_r_rdata_o,
    output logic [ID_WIDTH-1:0]       per_slave_r_id_o,

    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [31:0]               pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [31:0]               prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; it is cleared on each ACCESS entry.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_SETUP  = 3'd1,
        RD_ACCESS = 3'd2,
        WR_SETUP  = 3'd3,
        WR_ACCESS = 3'd4,
        RESP      = 3'd5
    } state_e;

    state_e                    state_q;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic                      we_q;
    logic [31:0]               wdata_q;
    logic [3:0]                be_q;
    logic [ID_WIDTH-1:0]       id_q;
    logic [CNT_W-1:0]          cnt_q;

    logic                      psel_q;
    logic                      penable_q;
    logic                      pwrite_q;
    logic [31:0]               pwdata_q;
    logic                      r_valid_q;
    logic                      r_opc_q;
    logic [31:0]               r_rdata_q;
    logic [ID_WIDTH-1:0]       r_id_q;

    logic                      timeout_c;
    logic [31:0]               pwdata_merge_d;
    logic                      unused_add;

    // Only the APB-visible, word-aligned address bits are kept.
    assign unused_add = ^per_slave_add_i;

    // Grant is a pure pass-through of req while idle.
    assign per_slave_gnt_o = per_slave_req_i & (state_q == IDLE);

    assign timeout_c = TO_EN && (cnt_q == CNT_LAST);

    // Read-modify-write data: enabled bytes from the request, the rest from the APB read.
    always_comb begin
        pwdata_merge_d = prdata_i;
        for (int k = 0; k < 4; k++) begin
            if (be_q[k]) begin
                pwdata_merge_d[8*k +: 8] = wdata_q[8*k +: 8];
            end
        end
    end

    // Bridge FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            r_valid_q <= 1'b0;
            r_opc_q   <= 1'b0;
            r_rdata_q <= '0;
            r_id_q    <= '0;
        end else begin
            // Response fields are only meaningful during the RESP pulse.
            r_valid_q <= 1'b0;
            r_opc_q   <= 1'b0;
            r_rdata_q <= '0;
            r_id_q    <= '0;

            case (state_q)
                IDLE: begin
                    if (per_slave_req_i) begin
                        addr_q  <= {per_slave_add_i[APB_ADDR_WIDTH-1:2], 2'b00};
                        we_q    <= per_slave_we_i;
                        wdata_q <= per_slave_wdata_i;
                        be_q    <= per_slave_be_i;
                        id_q    <= per_slave_id_i;
                        if (per_slave_we_i && (per_slave_be_i == 4'h0)) begin
                            // Nothing to write: answer immediately, APB untouched.
                            state_q   <= RESP;
                            r_valid_q <= 1'b1;
                            r_id_q    <= per_slave_id_i;
                        end else if (per_slave_we_i && (per_slave_be_i == 4'hF)) begin
                            state_q   <= WR_SETUP;
                            psel_q    <= 1'b1;
                            penable_q <= 1'b0;
                            pwrite_q  <= 1'b1;
                            pwdata_q  <= per_slave_wdata_i;
                        end else begin
                            // Reads and partial writes both start with an APB read.
                            state_q   <= RD_SETUP;
                            psel_q    <= 1'b1;
                            penable_q <= 1'b0;
                            pwrite_q  <= 1'b0;
                        end
                    end
                end

                RD_SETUP: begin
                    state_q   <= RD_ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end

                RD_ACCESS: begin
                    if (pready_i) begin
                        if (we_q && !pslverr_i) begin
                            // Partial write: second phase writes the merged word.
                            state_q   <= WR_SETUP;
                            penable_q <= 1'b0;
                            pwrite_q  <= 1'b1;
                            pwdata_q  <= pwdata_merge_d;
                        end else begin
                            state_q   <= RESP;
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                            r_valid_q <= 1'b1;
                            r_opc_q   <= pslverr_i;
                            r_rdata_q <= we_q ? 32'h0 : prdata_i;
                            r_id_q    <= id_q;
                        end
                    end else if (timeout_c) begin
                        state_q   <= RESP;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        r_valid_q <= 1'b1;
                        r_opc_q   <= 1'b1;
                        r_id_q    <= id_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                WR_SETUP: begin
                    state_q   <= WR_ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end

                WR_ACCESS: begin
                    if (pready_i || timeout_c) begin
                        state_q   <= RESP;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        r_valid_q <= 1'b1;
                        r_opc_q   <= pready_i ? pslverr_i : 1'b1;
                        r_id_q    <= id_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q   <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    pwrite_q  <= 1'b0;
                end
            endcase
        end
    end

    assign paddr_o             = addr_q;
    assign pwdata_o            = pwdata_q;
    assign pwrite_o            = pwrite_q;
    assign psel_o              = psel_q;
    assign penable_o           = penable_q;
    assign per_slave_r_valid_o = r_valid_q;
    assign per_slave_r_opc_o   = r_opc_q;
    assign per_slave_r_rdata_o = r_rdata_q;
    assign per_slave_r_id_o    = r_id_q;

endmodule
